cmac_tx_frame_buffer: RTL and testbench
=======================================

# cmac_tx_frame_buffer

Store-and-forward frame buffer on the transmit path, directly upstream of the CMAC AXI2LBUS stream input, in the `usr_tx_clk` domain. It accepts 512-bit AXI4-Stream frames from user logic and releases a frame only after its `tlast` beat is stored. The CMAC therefore sees `tvalid` held continuously from first beat to `tlast`, and TX underrun cannot occur. Frames longer than the buffer are discarded whole, never truncated.

## Interface
- `DEPTH`, 64: buffer depth in 512-bit beats; power of two, ≥ 4.
- `usr_tx_clk`  in  1  clock; the CMAC TX user clock.
- `tx_rst`  in  1  reset; asynchronous, active-high.
- `S_AXIS_tdata`  in  512  input frame data.
- `S_AXIS_tstrb`  in  64  byte-valid (keep semantics); stored and forwarded unmodified.
- `S_AXIS_tvalid`  in  1  input beat valid.
- `S_AXIS_tlast`  in  1  last beat of the frame.
- `S_AXIS_tready`  out  1  input beat accepted when high together with `tvalid`.
- `M_AXIS_tdata` / `M_AXIS_tstrb` / `M_AXIS_tvalid` / `M_AXIS_tlast`  out  512/64/1/1  output toward AXI2LBUS.
- `M_AXIS_tready`  in  1  CMAC ready.
- `overflow_drop`  out  1  one-cycle pulse when an oversize frame's `tlast` is discarded.

## Operation
- Storage is a DEPTH-entry dual-port RAM with three pointers, each log2(DEPTH)+1 bits wide so they wrap naturally:
  - `wr_ptr`: speculative write pointer.
  - `commit_ptr`: end of the last complete frame.
  - `rd_ptr`: read pointer.
- `full = (wr_ptr - rd_ptr) == DEPTH`.
- `frame_beats` counts beats of the in-progress frame; it saturates at DEPTH.
- Write FSM:
  - **IDLE_FILL**:
    - `S_AXIS_tready = !full`.
    - On each handshake: write beat, increment `wr_ptr` and `frame_beats`.
    - On a `tlast` handshake: `commit_ptr <= wr_ptr+1`, `frame_beats <= 0`.
    - If `full` and `frame_beats == DEPTH`: the frame cannot fit. Go to **DROP** and set `wr_ptr <= commit_ptr`.
    - If `full` and `frame_beats < DEPTH`: stall by holding `tready` low.
  - **DROP**:
    - `S_AXIS_tready = 1`; beats are discarded.
    - On a `tlast` handshake: pulse `overflow_drop`, clear `frame_beats`, return to **IDLE_FILL**.
- A frame of exactly DEPTH beats with `tlast` on beat DEPTH is stored and sent normally.
- Read side:
  - Only the range [`rd_ptr`, `commit_ptr`) is readable.
  - A one-entry output register, with a prefetch so the RAM read latency is hidden, drives `M_AXIS`.
  - The output register holds data while `M_AXIS_tvalid && !M_AXIS_tready`.
- Simultaneous commit and read in the same cycle are both honoured. The read side uses the pre-update `commit_ptr`, so the new frame becomes readable one cycle later.
- Reset outputs:
  - `S_AXIS_tready=0` in the cycle `tx_rst` is asserted.
  - `S_AXIS_tready=1` from the first clock after deassertion.
  - `M_AXIS_tvalid=0`, `M_AXIS_tlast=0`, `M_AXIS_tdata/tstrb=0`, `overflow_drop=0`.
  - All pointers 0, FSM in IDLE_FILL.
- Reset mid-frame discards all buffered and partial frames; no partial frame is emitted afterwards.

## Timing
- Store-and-forward latency: first beat on `M_AXIS_tvalid` 2 cycles after the `tlast` handshake on S, when the buffer holds no earlier frame.
- Throughput: one beat per cycle in each direction concurrently.
- Once the first beat of a frame is presented, `M_AXIS_tvalid` stays high every cycle until its `tlast` handshake. No bubbles are allowed mid-frame.
- Back-to-back frames already committed: first beat of frame N+1 presented in the cycle after the `tlast` handshake of frame N.
- `full` and `tready` are combinational from registered pointers. No combinational path from `M_AXIS_tready` to `S_AXIS_tready`.

## Configuration
- `CMAC_TX_BUF_STATS_EN` defined adds two outputs:
  - `stat_frames_tx` (32 bits): increments one cycle after each M-side `tlast` handshake.
  - `stat_frames_dropped` (32 bits): increments one cycle after each `overflow_drop` pulse.
  - Both saturate at 0xFFFFFFFF and reset to 0 on `tx_rst`.
- Undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Single 3-beat frame, M ready always → `S_AXIS_tready` stays 1. M emits 3 beats on consecutive cycles, first at `tlast`-handshake+2. `tdata/tstrb` match input; `tlast` on beat 3 only.
- 8-beat frame with random gaps in S `tvalid` → M output is 8 contiguous valid cycles with no bubbles.
- DEPTH=64, 65-beat frame followed by a 2-beat frame:
  - `S_AXIS_tready` stays 1.
  - `overflow_drop` pulses once on beat 65.
  - M emits only the 2-beat frame.
  - `stat_frames_dropped=1` with the macro defined.
- Exactly 64-beat frame → stored and emitted intact; `overflow_drop` stays 0.
- M_AXIS_tready held 0 while sixteen 4-beat frames are written:
  - `S_AXIS_tready` falls when 64 beats are stored.
  - Releasing `M_AXIS_tready` drains all 16 frames in order.
  - `stat_frames_tx=16`.
- `tx_rst` asserted mid-way through an incoming frame and mid-way through an outgoing frame:
  - M outputs go to 0 immediately.
  - After reset a new 2-beat frame is emitted alone.

Source files
------------

// File: rtl/cmac_tx_frame_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmac_tx_frame_buffer                                                      |
// | Store-and-forward TX frame buffer ahead of CMAC AXI2LBUS; oversize frames |
// | are dropped whole. Optional counters: define CMAC_TX_BUF_STATS_EN.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module cmac_tx_frame_buffer #(
  parameter int DEPTH = 64
) (
  input  logic         usr_tx_clk,
  input  logic         tx_rst,
  input  logic [511:0] S_AXIS_tdata,
  input  logic [63:0]  S_AXIS_tstrb,
  input  logic         S_AXIS_tvalid,
  input  logic         S_AXIS_tlast,
  output logic         S_AXIS_tready,
  output logic [511:0] M_AXIS_tdata,
  output logic [63:0]  M_AXIS_tstrb,
  output logic         M_AXIS_tvalid,
  output logic         M_AXIS_tlast,
  input  logic         M_AXIS_tready,
  output logic         overflow_drop
`ifdef CMAC_TX_BUF_STATS_EN
  ,
  output logic [31:0]  stat_frames_tx,
  output logic [31:0]  stat_frames_dropped
`endif
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_dw = 512 + 64 + 1;
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0] c_one   = (c_aw + 1)'(1);

  typedef enum logic [0:0] {
    IDLE_FILL = 1'b0,
    DROP      = 1'b1
  } wr_state_t;

  wr_state_t r_state, w_state_nxt;

  logic [c_dw-1:0] r_mem [DEPTH];
  logic [c_aw:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr, r_fetch_ptr, r_frame_beats;
  logic [c_aw:0]   w_wr_ptr_nxt, w_commit_ptr_nxt, w_frame_beats_nxt;
  logic            r_rst_done;
  logic            w_full, w_oversize, w_drop_mode, w_s_hs, w_m_hs, w_load, w_mem_we;
  logic            w_overflow_drop;
  logic            r_m_valid, r_m_last;
  logic [511:0]    r_m_data;
  logic [63:0]     r_m_strb;

  // rd_ptr trails the output register: a RAM slot is only freed once the CMAC takes the beat
  assign w_full        = (r_wr_ptr - r_rd_ptr) == c_depth;
  assign w_oversize    = w_full && (r_frame_beats == c_depth);
  assign w_drop_mode   = (r_state == DROP) || w_oversize;
  assign S_AXIS_tready = r_rst_done && (w_drop_mode || !w_full);
  assign w_s_hs        = S_AXIS_tvalid && S_AXIS_tready;
  assign overflow_drop = w_overflow_drop;

  always_comb begin
    w_state_nxt       = r_state;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_commit_ptr_nxt  = r_commit_ptr;
    w_frame_beats_nxt = r_frame_beats;
    w_mem_we          = 1'b0;
    w_overflow_drop   = 1'b0;
    if (w_drop_mode) begin
      // The beat that would overflow is already being discarded here, so tready never dips
      w_wr_ptr_nxt = r_commit_ptr;
      w_state_nxt  = DROP;
      if (w_s_hs && S_AXIS_tlast) begin
        w_overflow_drop   = 1'b1;
        w_frame_beats_nxt = '0;
        w_state_nxt       = IDLE_FILL;
      end
    end else if (w_s_hs) begin
      w_mem_we          = 1'b1;
      w_wr_ptr_nxt      = r_wr_ptr + c_one;
      w_frame_beats_nxt = (r_frame_beats == c_depth) ? r_frame_beats : r_frame_beats + c_one;
      if (S_AXIS_tlast) begin
        w_commit_ptr_nxt  = r_wr_ptr + c_one;
        w_frame_beats_nxt = '0;
      end
    end
  end

  always_ff @(posedge usr_tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_state       <= IDLE_FILL;
      r_wr_ptr      <= '0;
      r_commit_ptr  <= '0;
      r_frame_beats <= '0;
      r_rst_done    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_commit_ptr  <= w_commit_ptr_nxt;
      r_frame_beats <= w_frame_beats_nxt;
      r_rst_done    <= 1'b1;
    end
  end

  always_ff @(posedge usr_tx_clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {S_AXIS_tdata, S_AXIS_tstrb, S_AXIS_tlast};
    end
  end

  // Output register doubles as the RAM read register; refilled whenever empty or consumed
  assign w_m_hs = r_m_valid && M_AXIS_tready;
  assign w_load = (r_fetch_ptr != r_commit_ptr) && (!r_m_valid || M_AXIS_tready);

  always_ff @(posedge usr_tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_data    <= '0;
      r_m_strb    <= '0;
    end else begin
      if (w_m_hs) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      if (w_load) begin
        {r_m_data, r_m_strb, r_m_last} <= r_mem[r_fetch_ptr[c_aw-1:0]];
        r_m_valid   <= 1'b1;
        r_fetch_ptr <= r_fetch_ptr + c_one;
      end else if (w_m_hs) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign M_AXIS_tdata  = r_m_data;
  assign M_AXIS_tstrb  = r_m_strb;
  assign M_AXIS_tvalid = r_m_valid;
  assign M_AXIS_tlast  = r_m_last;

`ifdef CMAC_TX_BUF_STATS_EN
  logic [31:0] r_stat_tx, r_stat_drop;

  always_ff @(posedge usr_tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      r_stat_tx   <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_m_hs && r_m_last && (r_stat_tx != 32'hFFFF_FFFF)) begin
        r_stat_tx <= r_stat_tx + 32'd1;
      end
      if (w_overflow_drop && (r_stat_drop != 32'hFFFF_FFFF)) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  assign stat_frames_tx      = r_stat_tx;
  assign stat_frames_dropped = r_stat_drop;
`else
  // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmac_tx_frame_buffer.sv
`default_nettype none
// Scoreboard bench for cmac_tx_frame_buffer: expected beats are queued as frames are
// driven and popped as the CMAC side accepts them.
module tb_cmac_tx_frame_buffer;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [511:0] s_tdata = '0;
  logic [63:0]  s_tstrb = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tstrb;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;
  logic         ovf;
`ifdef CMAC_TX_BUF_STATS_EN
  logic [31:0]  stat_tx;
  logic [31:0]  stat_drop;
`endif

  cmac_tx_frame_buffer #(.DEPTH(DEPTH)) dut (
    .usr_tx_clk    (clk),
    .tx_rst        (rst),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tstrb  (s_tstrb),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tlast  (s_tlast),
    .S_AXIS_tready (s_tready),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tstrb  (m_tstrb),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tlast  (m_tlast),
    .M_AXIS_tready (m_tready),
    .overflow_drop (ovf)
`ifdef CMAC_TX_BUF_STATS_EN
    ,
    .stat_frames_tx      (stat_tx),
    .stat_frames_dropped (stat_drop)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [576:0] got, input logic [576:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [576:0] exp_q[$];
  int  exp_frames = 0;
  int  m_frames = 0;
  int  drop_cnt = 0;
  int  s_stalls = 0;
  int  first_valid_cyc = 0;
  int  hs_cyc = 0;
  bit  in_frame = 1'b0;
  bit  prev_valid = 1'b0;

  // Output monitor: scoreboard compare, bubble detection, event counters
  always @(negedge clk) begin
    if (rst) begin
      in_frame   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (in_frame) check_eq("m_no_bubble", m_tvalid, 1);
      if (m_tvalid && !prev_valid) first_valid_cyc = cyc;
      prev_valid = m_tvalid;
      if (s_tvalid && !s_tready) s_stalls++;
      if (ovf) drop_cnt++;
      if (m_tvalid && m_tready) begin
        check_eq("m_beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("m_beat", {m_tdata, m_tstrb, m_tlast}, exp_q.pop_front());
        in_frame = !m_tlast;
        if (m_tlast) m_frames++;
      end
    end
  end

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                            output logic od);
    int t;
    t  = 0;
    od = 1'b0;
    s_tdata = d; s_tstrb = k; s_tlast = l; s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        od     = ovf;
        hs_cyc = cyc;
        break;
      end
      t++;
      if (t > 500) begin
        check_eq("s_handshake_timeout", t, 0);
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit keep, input int gap_max, output logic od_last);
    logic [511:0] d;
    logic [63:0]  k;
    logic [63:0]  ones;
    logic         l;
    int           g;
    ones = '1;
    od_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = rand512();
      l = (i == n - 1);
      k = l ? (ones >> $urandom_range(0, 63)) : ones;
      if (keep) exp_q.push_back({d, k, l});
      drive_beat(d, k, l, od_last);
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
    if (keep) exp_frames++;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic od;
    int   frames0, drops0;

    // Reset values
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_s_tready", s_tready, 0);
    check_eq("rst_m_tvalid", m_tvalid, 0);
    check_eq("rst_m_tlast", m_tlast, 0);
    check_eq("rst_m_tdata", m_tdata, 0);
    check_eq("rst_m_tstrb", m_tstrb, 0);
    check_eq("rst_overflow", ovf, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_s_tready", s_tready, 1);
    @(posedge clk); #1;

    // Single 3-beat frame: latency and stall-free input
    s_stalls = 0;
    send_frame(3, 1'b1, 0, od);
    wait_drain();
    check_eq("f3_latency", first_valid_cyc - hs_cyc, 2);
    check_eq("f3_no_stall", s_stalls, 0);
    check_eq("f3_frames", m_frames, 1);

    // 8-beat frame with random input gaps
    send_frame(8, 1'b1, 3, od);
    wait_drain();
    check_eq("f8_latency", first_valid_cyc - hs_cyc, 2);
    check_eq("f8_frames", m_frames, 2);

    // Oversize 65-beat frame dropped, 2-beat frame forwarded
    s_stalls = 0;
    drops0   = drop_cnt;
    frames0  = m_frames;
    send_frame(DEPTH + 1, 1'b0, 0, od);
    check_eq("ovf_pulse_on_last", od, 1);
    send_frame(2, 1'b1, 0, od);
    wait_drain();
    check_eq("ovf_no_stall", s_stalls, 0);
    check_eq("ovf_drop_count", drop_cnt - drops0, 1);
    check_eq("ovf_frames_out", m_frames - frames0, 1);
`ifdef CMAC_TX_BUF_STATS_EN
    check_eq("stat_dropped_1", stat_drop, 1);
    check_eq("stat_tx_3", stat_tx, exp_frames);
`endif

    // Exactly DEPTH beats fits
    s_stalls = 0;
    drops0   = drop_cnt;
    send_frame(DEPTH, 1'b1, 0, od);
    check_eq("full_frame_no_ovf", od, 0);
    wait_drain();
    check_eq("full_frame_no_drop", drop_cnt - drops0, 0);
    check_eq("full_frame_no_stall", s_stalls, 0);

    // Sixteen 4-beat frames with CMAC back-pressured
    m_tready = 1'b0;
    s_stalls = 0;
    frames0  = m_frames;
    for (int f = 0; f < 16; f++) send_frame(4, 1'b1, 0, od);
    check_eq("bp_no_stall_64", s_stalls, 0);
    @(negedge clk);
    check_eq("bp_s_tready_full", s_tready, 0);
    check_eq("bp_m_tvalid_held", m_tvalid, 1);
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_drain();
    check_eq("bp_frames_out", m_frames - frames0, 16);
`ifdef CMAC_TX_BUF_STATS_EN
    check_eq("stat_tx_total", stat_tx, exp_frames);
`endif

    // Reset mid-frame on both sides
    m_tready = 1'b0;
    send_frame(6, 1'b1, 0, od);
    for (int i = 0; i < 3; i++) drive_beat(rand512(), '1, 1'b0, od);
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_m_tvalid", m_tvalid, 0);
    check_eq("midrst_m_tdata", m_tdata, 0);
    check_eq("midrst_m_tlast", m_tlast, 0);
    check_eq("midrst_s_tready", s_tready, 0);
    exp_q.delete();
    exp_frames = 0;
    frames0    = m_frames;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
`ifdef CMAC_TX_BUF_STATS_EN
    check_eq("midrst_stat_tx_zero", stat_tx, 0);
    check_eq("midrst_stat_drop_zero", stat_drop, 0);
`endif
    send_frame(2, 1'b1, 0, od);
    wait_drain();
    repeat (20) @(posedge clk);
    #1;
    check_eq("midrst_frames_out", m_frames - frames0, 1);
    check_eq("midrst_idle_after", m_tvalid, 0);
`ifdef CMAC_TX_BUF_STATS_EN
    check_eq("midrst_stat_tx_one", stat_tx, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
